// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 UART transmit serializer with valid/ready byte input
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [CNT_W-1:0]     clk_cnt;
    logic [2:0]           bit_cnt;

    // Ready depends only on registered state, never on tx_valid.
    assign tx_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_valid) begin
                        shift_reg <= tx_data;
                        bit_cnt   <= '0;
                        clk_cnt   <= '0;
                        state     <= START;
                        tx        <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        state   <= DATA;
                        tx      <= shift_reg[0];
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            // tx takes the bit that becomes shift_reg[0] after this shift.
                            shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
                            tx        <= shift_reg[1];
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        tx      <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
